// File: rtl/sim_run_supervisor.sv
`timescale 1ns/1ps
// Simulation run supervisor: sequences harness reset, counts run cycles and folds
// per-channel success/failure/progress into one registered terminal verdict.
// States: HOLD harness reset | RUN monitor | DRAIN settle after all-success | PASS/FAIL terminal
module sim_run_supervisor #(
    parameter int NUM_CH       = 2,
    parameter int CNT_W        = 64,
    parameter int RESET_CYCLES = 16,
    parameter int DRAIN_CYCLES = 8,
    parameter int STALL_CYCLES = 0,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CNT_W-1:0]  max_cycles,
    input  logic [NUM_CH-1:0] io_success,
    input  logic [NUM_CH-1:0] io_failure,
    input  logic [NUM_CH-1:0] io_progress,
    output logic              dut_reset,
    output logic              running,
    output logic              done,
    output logic              passed,
    output logic [1:0]        fail_code,
    output logic [CH_W-1:0]   fail_chan,
    output logic [NUM_CH-1:0] success_mask,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam int HOLD_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int STALL_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_HOLD  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_PASS  = 3'd3,
        ST_FAIL  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [STALL_W-1:0]  stall_q, stall_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;
    logic [CNT_W-1:0]    cycle_q, cycle_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [1:0]          code_q, code_d;
    logic [CH_W-1:0]     chan_q, chan_d;
    logic                dut_reset_q, running_q, done_q, passed_q;

    logic [CH_W-1:0]     low_fail;
    logic [CNT_W-1:0]    cycle_inc;
    logic                any_fail, any_prog, timeout_hit, stall_hit;

    always_comb begin
        low_fail = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (io_failure[i]) low_fail = CH_W'(i);
        end
    end

    assign any_fail    = |io_failure;
    assign any_prog    = |io_progress;
    assign cycle_inc   = (&cycle_q) ? cycle_q : cycle_q + CNT_W'(1);
    assign timeout_hit = (max_cycles != '0) && (cycle_q >= max_cycles);
    assign stall_hit   = (STALL_CYCLES != 0) && (stall_q == STALL_W'(STALL_CYCLES - 1)) && !any_prog;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        stall_d = stall_q;
        drain_d = drain_q;
        cycle_d = cycle_q;
        mask_d  = mask_q;
        code_d  = code_q;
        chan_d  = chan_q;
        case (state_q)
            ST_HOLD: begin
                if (hold_q == HOLD_W'(RESET_CYCLES - 1)) state_d = ST_RUN;
                else                                     hold_d  = hold_q + HOLD_W'(1);
            end
            ST_RUN: begin
                mask_d  = mask_q | io_success;
                cycle_d = cycle_inc;
                stall_d = any_prog ? '0 : stall_q + STALL_W'(1);
                // The deciding cycle is not counted on a fail, so cycle_count names it.
                if (any_fail) begin
                    state_d = ST_FAIL;
                    code_d  = 2'd1;
                    chan_d  = low_fail;
                    cycle_d = cycle_q;
                end else if (timeout_hit) begin
                    state_d = ST_FAIL;
                    code_d  = 2'd2;
                    cycle_d = cycle_q;
                end else if (stall_hit) begin
                    state_d = ST_FAIL;
                    code_d  = 2'd3;
                    cycle_d = cycle_q;
                end else if (&mask_d) begin
                    state_d = (DRAIN_CYCLES == 0) ? ST_PASS : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                cycle_d = cycle_inc;
                if (any_fail) begin
                    state_d = ST_FAIL;
                    code_d  = 2'd1;
                    chan_d  = low_fail;
                    cycle_d = cycle_q;
                end else if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                    state_d = ST_PASS;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_HOLD;
            hold_q      <= '0;
            stall_q     <= '0;
            drain_q     <= '0;
            cycle_q     <= '0;
            mask_q      <= '0;
            code_q      <= '0;
            chan_q      <= '0;
            dut_reset_q <= 1'b1;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            passed_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            stall_q     <= stall_d;
            drain_q     <= drain_d;
            cycle_q     <= cycle_d;
            mask_q      <= mask_d;
            code_q      <= code_d;
            chan_q      <= chan_d;
            dut_reset_q <= (state_d == ST_HOLD);
            running_q   <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
            done_q      <= (state_d == ST_PASS) || (state_d == ST_FAIL);
            passed_q    <= (state_d == ST_PASS);
        end
    end

    assign dut_reset    = dut_reset_q;
    assign running      = running_q;
    assign done         = done_q;
    assign passed       = passed_q;
    assign fail_code    = code_q;
    assign fail_chan    = chan_q;
    assign success_mask = mask_q;
    assign cycle_count  = cycle_q;

endmodule

// File: tb/tb_sim_run_supervisor.sv
`timescale 1ns/1ps
// Randomised and directed bench for sim_run_supervisor; expected verdicts come from a
// cycle-indexed reference model over the stimulus tables.
module tb_sim_run_supervisor;

    localparam int NCH   = 2;
    localparam int HOLDN = 4;
    localparam int DRAIN = 3;
    localparam int STALL = 8;
    localparam int MAXK  = 300;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] max_cycles;
    logic [1:0]  io_success, io_failure, io_progress;
    logic        dut_reset, running, done, passed;
    logic [1:0]  fail_code;
    logic [0:0]  fail_chan;
    logic [1:0]  success_mask;
    logic [63:0] cycle_count;

    logic        sat_succ;
    logic        sat_dut_reset, sat_running, sat_done, sat_passed;
    logic [1:0]  sat_code;
    logic [0:0]  sat_chan;
    logic [0:0]  sat_mask;
    logic [3:0]  sat_count;

    always #5 clk = ~clk;

    sim_run_supervisor #(.NUM_CH(NCH), .CNT_W(64), .RESET_CYCLES(HOLDN),
                         .DRAIN_CYCLES(DRAIN), .STALL_CYCLES(STALL)) u_dut (
        .clk(clk), .reset(reset), .max_cycles(max_cycles),
        .io_success(io_success), .io_failure(io_failure), .io_progress(io_progress),
        .dut_reset(dut_reset), .running(running), .done(done), .passed(passed),
        .fail_code(fail_code), .fail_chan(fail_chan), .success_mask(success_mask),
        .cycle_count(cycle_count)
    );

    // Narrow counter, no drain, no stall watchdog: exercises saturation and immediate PASS.
    sim_run_supervisor #(.NUM_CH(1), .CNT_W(4), .RESET_CYCLES(1),
                         .DRAIN_CYCLES(0), .STALL_CYCLES(0)) u_sat (
        .clk(clk), .reset(reset), .max_cycles(4'd0),
        .io_success(sat_succ), .io_failure(1'b0), .io_progress(1'b0),
        .dut_reset(sat_dut_reset), .running(sat_running), .done(sat_done), .passed(sat_passed),
        .fail_code(sat_code), .fail_chan(sat_chan), .success_mask(sat_mask),
        .cycle_count(sat_count)
    );

    int tests = 0;
    int fails = 0;

    logic [1:0]  st_succ [MAXK];
    logic [1:0]  st_fail [MAXK];
    logic [1:0]  st_prog [MAXK];

    logic [8:0]  rst_obs;
    logic [63:0] rst_cnt;
    int          hold_hi;
    int          seen_end;
    logic [8:0]  obs;
    logic [63:0] obs_cnt;

    int          e_end, e_chan;
    bit          e_pass;
    logic [1:0]  e_code, e_mask;
    longint      e_count;

    function automatic logic [8:0] exp_flags();
        return {e_end >= 0, e_pass, e_end < 0, 1'b0, e_code, 1'(e_chan), e_mask};
    endfunction

    task automatic clear_stim(input logic [1:0] prog);
        for (int k = 0; k < MAXK; k++) begin
            st_succ[k] = 2'b00;
            st_fail[k] = 2'b00;
            st_prog[k] = prog;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        io_success = 2'b00; io_failure = 2'b00; io_progress = 2'b00;
        @(posedge clk); #1;
        rst_obs = {dut_reset, running, done, passed, fail_code, fail_chan, success_mask};
        rst_cnt = cycle_count;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Counts negedge samples with dut_reset high; junk on harness inputs must be ignored.
    task automatic hold_phase();
        hold_hi = 0;
        for (int i = 0; i < 20; i++) begin
            io_success = 2'($urandom); io_failure = 2'($urandom); io_progress = 2'($urandom);
            if (!dut_reset) break;
            hold_hi++;
            @(negedge clk);
        end
    endtask

    task automatic run_phase(input int ncyc);
        seen_end = -1;
        for (int k = 0; k < ncyc; k++) begin
            io_success = st_succ[k]; io_failure = st_fail[k]; io_progress = st_prog[k];
            @(posedge clk); #1;
            if (done) begin
                seen_end = k;
                break;
            end
            @(negedge clk);
        end
        if (seen_end >= 0) begin
            repeat (3) begin
                @(negedge clk);
                io_success = 2'($urandom); io_failure = 2'($urandom); io_progress = 2'($urandom);
            end
            @(posedge clk); #1;
        end
        obs     = {done, passed, running, dut_reset, fail_code, fail_chan, success_mask};
        obs_cnt = cycle_count;
    endtask

    // Reference: RUN cycle k sees table entry k; the verdict is decided in cycle e_end.
    task automatic model(input longint maxc, input int ncyc);
        int last;
        logic [1:0] m;
        e_mask = 2'b00; e_end = -1; e_pass = 0; e_code = 2'd0; e_chan = 0;
        e_count = ncyc; last = -1;
        for (int k = 0; k < ncyc; k++) begin
            m = e_mask | st_succ[k];
            if (st_fail[k] != 0) begin
                e_code = 2'd1; e_end = k; e_count = k; e_mask = m;
                e_chan = st_fail[k][0] ? 0 : 1;
                return;
            end
            if (maxc != 0 && k >= maxc) begin
                e_code = 2'd2; e_end = k; e_count = k; e_mask = m;
                return;
            end
            if (st_prog[k] == 0 && (k - last) >= STALL) begin
                e_code = 2'd3; e_end = k; e_count = k; e_mask = m;
                return;
            end
            if (st_prog[k] != 0) last = k;
            e_mask = m;
            if (m == 2'b11) begin
                for (int j = 1; j <= DRAIN; j++) begin
                    if (st_fail[k+j] != 0) begin
                        e_code = 2'd1; e_end = k + j; e_count = k + j;
                        e_chan = st_fail[k+j][0] ? 0 : 1;
                        return;
                    end
                end
                e_pass = 1; e_end = k + DRAIN; e_count = k + DRAIN + 1;
                return;
            end
        end
    endtask

    task automatic run_scenario(input longint maxc, input int ncyc);
        max_cycles = 64'(maxc);
        apply_reset();
        hold_phase();
        run_phase(ncyc);
        model(maxc, ncyc);
    endtask

    task automatic test_reset();
        max_cycles = 64'd0;
        apply_reset();
        tests++;
        if (rst_obs !== 9'b1_0_0_0_00_0_00 || rst_cnt !== 64'd0) begin
            fails++;
            $display("FAIL reset_state: got flags=%b cnt=%0d, expected flags=100000000 cnt=0", rst_obs, rst_cnt);
        end
        hold_phase();
        tests++;
        if (hold_hi != HOLDN) begin
            fails++;
            $display("FAIL hold_length: got %0d cycles, expected %0d", hold_hi, HOLDN);
        end
        tests++;
        if (running !== 1'b1 || cycle_count !== 64'd0 || done !== 1'b0) begin
            fails++;
            $display("FAIL run_entry: got running=%b cnt=%0d done=%b, expected 1 0 0", running, cycle_count, done);
        end
    endtask

    task automatic test_pass();
        clear_stim(2'b11);
        st_succ[10] = 2'b01;
        st_succ[20] = 2'b10;
        run_scenario(0, MAXK);
        tests++;
        if ({obs, obs_cnt} !== {exp_flags(), 64'(e_count)} || seen_end != e_end) begin
            fails++;
            $display("FAIL pass_model: got end=%0d flags=%b cnt=%0d, expected end=%0d flags=%b cnt=%0d", seen_end, obs, obs_cnt, e_end, exp_flags(), e_count);
        end
        tests++;
        if (done !== 1'b1 || passed !== 1'b1 || success_mask !== 2'b11 || cycle_count !== 64'd24) begin
            fails++;
            $display("FAIL pass_const: got done=%b passed=%b mask=%b cnt=%0d, expected 1 1 11 24", done, passed, success_mask, cycle_count);
        end
    endtask

    task automatic test_fail_priority();
        clear_stim(2'b11);
        st_fail[5] = 2'b10;
        st_succ[5] = 2'b11;
        run_scenario(0, MAXK);
        tests++;
        if ({obs, obs_cnt} !== {exp_flags(), 64'(e_count)} || seen_end != e_end) begin
            fails++;
            $display("FAIL fail_prio_model: got end=%0d flags=%b cnt=%0d, expected end=%0d flags=%b cnt=%0d", seen_end, obs, obs_cnt, e_end, exp_flags(), e_count);
        end
        tests++;
        if (passed !== 1'b0 || fail_code !== 2'd1 || fail_chan !== 1'b1) begin
            fails++;
            $display("FAIL fail_prio_const: got passed=%b code=%0d chan=%0d, expected 0 1 1", passed, fail_code, fail_chan);
        end
    endtask

    task automatic test_timeout();
        clear_stim(2'b11);
        run_scenario(50, MAXK);
        tests++;
        if ({obs, obs_cnt} !== {exp_flags(), 64'(e_count)} || seen_end != e_end) begin
            fails++;
            $display("FAIL timeout_model: got end=%0d flags=%b cnt=%0d, expected end=%0d flags=%b cnt=%0d", seen_end, obs, obs_cnt, e_end, exp_flags(), e_count);
        end
        tests++;
        if (fail_code !== 2'd2 || cycle_count !== 64'd50) begin
            fails++;
            $display("FAIL timeout_const: got code=%0d cnt=%0d, expected 2 50", fail_code, cycle_count);
        end
    endtask

    task automatic test_no_timeout();
        clear_stim(2'b11);
        run_scenario(0, 100);
        tests++;
        if ({obs, obs_cnt} !== {exp_flags(), 64'(e_count)} || seen_end != e_end) begin
            fails++;
            $display("FAIL no_timeout_model: got end=%0d flags=%b cnt=%0d, expected end=%0d flags=%b cnt=%0d", seen_end, obs, obs_cnt, e_end, exp_flags(), e_count);
        end
        tests++;
        if (done !== 1'b0 || running !== 1'b1 || cycle_count !== 64'd100) begin
            fails++;
            $display("FAIL no_timeout_const: got done=%b running=%b cnt=%0d, expected 0 1 100", done, running, cycle_count);
        end
    endtask

    task automatic test_stall();
        for (int pass_i = 0; pass_i < 2; pass_i++) begin
            clear_stim(2'b00);
            for (int k = 0; k <= 12; k++) st_prog[k] = 2'b11;
            if (pass_i == 1) st_prog[19] = 2'b01;
            run_scenario(0, MAXK);
            tests++;
            if ({obs, obs_cnt} !== {exp_flags(), 64'(e_count)} || seen_end != e_end) begin
                fails++;
                $display("FAIL stall_model[%0d]: got end=%0d flags=%b cnt=%0d, expected end=%0d flags=%b cnt=%0d", pass_i, seen_end, obs, obs_cnt, e_end, exp_flags(), e_count);
            end
            tests++;
            if (fail_code !== 2'd3 || cycle_count !== 64'(pass_i == 1 ? 27 : 20)) begin
                fails++;
                $display("FAIL stall_const[%0d]: got code=%0d cnt=%0d, expected 3 %0d", pass_i, fail_code, cycle_count, pass_i == 1 ? 27 : 20);
            end
        end
    endtask

    task automatic test_random();
        longint maxc;
        for (int it = 0; it < 25; it++) begin
            clear_stim(2'b00);
            for (int k = 0; k < MAXK - 10; k++) begin
                st_succ[k] = {($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0)};
                st_fail[k] = {($urandom_range(0, 79) == 0), ($urandom_range(0, 79) == 0)};
                if (it % 3 == 0) st_prog[k] = ($urandom_range(0, 9) < 7) ? 2'b00 : 2'($urandom);
                else             st_prog[k] = 2'($urandom);
            end
            maxc = (it % 4 == 0) ? 0 : longint'($urandom_range(20, 150));
            run_scenario(maxc, MAXK - 10);
            tests++;
            if ({obs, obs_cnt} !== {exp_flags(), 64'(e_count)} || seen_end != e_end) begin
                fails++;
                $display("FAIL random[%0d]: got end=%0d flags=%b cnt=%0d, expected end=%0d flags=%b cnt=%0d", it, seen_end, obs, obs_cnt, e_end, exp_flags(), e_count);
            end
        end
    endtask

    task automatic test_reset_in_drain();
        clear_stim(2'b11);
        st_succ[3] = 2'b11;
        max_cycles = 64'd0;
        apply_reset();
        hold_phase();
        run_phase(6);
        tests++;
        if (running !== 1'b1 || done !== 1'b0 || success_mask !== 2'b11) begin
            fails++;
            $display("FAIL drain_entry: got running=%b done=%b mask=%b, expected 1 0 11", running, done, success_mask);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        tests++;
        if ({dut_reset, running, done, passed, fail_code, fail_chan, success_mask} !== 9'b1_0_0_0_00_0_00 || cycle_count !== 64'd0) begin
            fails++;
            $display("FAIL drain_reset: got flags=%b cnt=%0d, expected flags=100000000 cnt=0", {dut_reset, running, done, passed, fail_code, fail_chan, success_mask}, cycle_count);
        end
        @(negedge clk);
        reset = 1'b1;
        hold_phase();
        tests++;
        if (hold_hi != HOLDN || running !== 1'b1) begin
            fails++;
            $display("FAIL drain_rehold: got %0d hold cycles running=%b, expected %0d 1", hold_hi, running, HOLDN);
        end
    endtask

    task automatic test_saturate();
        sat_succ = 1'b0;
        apply_reset();
        repeat (25) @(posedge clk);
        #1;
        tests++;
        if (sat_count !== 4'hF || sat_running !== 1'b1 || sat_done !== 1'b0) begin
            fails++;
            $display("FAIL saturate: got cnt=%0d running=%b done=%b, expected 15 1 0", sat_count, sat_running, sat_done);
        end
        @(negedge clk);
        sat_succ = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (sat_done !== 1'b1 || sat_passed !== 1'b1 || sat_code !== 2'd0 || sat_count !== 4'hF) begin
            fails++;
            $display("FAIL no_drain_pass: got done=%b passed=%b code=%0d cnt=%0d, expected 1 1 0 15", sat_done, sat_passed, sat_code, sat_count);
        end
        @(negedge clk);
        sat_succ = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        max_cycles = 64'd0;
        io_success = 2'b00; io_failure = 2'b00; io_progress = 2'b00;
        sat_succ = 1'b0;
        test_reset();
        test_pass();
        test_fail_priority();
        test_timeout();
        test_no_timeout();
        test_stall();
        test_random();
        test_reset_in_drain();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
